// File: rtl/branch_resolve_if.sv
// Bundle/redirect bus between operand-read and the branch resolution unit.
interface branch_resolve_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSLOT = 2
);
  logic                    valid;
  logic                    stall;
  logic [3*NSLOT-1:0]      br_op;
  logic [XLEN*NSLOT-1:0]   op1;
  logic [XLEN*NSLOT-1:0]   op2;
  logic [XLEN*NSLOT-1:0]   target;
  logic [XLEN-1:0]         fallthru;
  logic [NSLOT-1:0]        pred_taken;
  logic                    redirect_valid;
  logic [XLEN-1:0]         redirect_pc;
  logic                    flush;
  logic [31:0]             cnt_branch;
  logic [31:0]             cnt_mispred;

  modport master (
    output valid, stall, br_op, op1, op2, target, fallthru, pred_taken,
    input  redirect_valid, redirect_pc, flush, cnt_branch, cnt_mispred
  );

  modport slave (
    input  valid, stall, br_op, op1, op2, target, fallthru, pred_taken,
    output redirect_valid, redirect_pc, flush, cnt_branch, cnt_mispred
  );
endinterface

// File: rtl/branch_resolve.sv
// Multi-slot branch resolution: evaluates every branch slot of a bundle,
// redirects fetch on the oldest mispredicting slot and holds a flush window.
module branch_resolve #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NSLOT     = 2,
  parameter int unsigned FLUSH_LEN = 2
) (
  input logic               clk,
  input logic               rst,
  branch_resolve_if.slave   bus
);

  localparam int unsigned FW = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN + 1);
  localparam int unsigned CW = 3;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BLT  = 3'd3;
  localparam logic [2:0] OP_BGE  = 3'd4;
  localparam logic [2:0] OP_BLTU = 3'd5;
  localparam logic [2:0] OP_BGEU = 3'd6;
  localparam logic [2:0] OP_JR   = 3'd7;

  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            flush_q, flush_d;
  logic [31:0]     cnt_branch_q, cnt_branch_d;
  logic [31:0]     cnt_mispred_q, cnt_mispred_d;

  logic [NSLOT-1:0] taken_c;
  logic [NSLOT-1:0] is_br_c;
  logic [NSLOT-1:0] mis_c;
  logic             acc_c;
  logic             found_c;
  logic [XLEN-1:0]  win_pc_c;
  logic [CW-1:0]    inc_c;

  // Per-slot condition evaluation and misprediction detection.
  always_comb begin
    taken_c = '0;
    is_br_c = '0;
    mis_c   = '0;
    for (int i = 0; i < NSLOT; i++) begin
      logic [2:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      op = bus.br_op[i*3 +: 3];
      a  = bus.op1[i*XLEN +: XLEN];
      b  = bus.op2[i*XLEN +: XLEN];
      case (op)
        OP_BEQ:  taken_c[i] = (a == b);
        OP_BNE:  taken_c[i] = (a != b);
        OP_BLT:  taken_c[i] = ($signed(a) < $signed(b));
        OP_BGE:  taken_c[i] = !($signed(a) < $signed(b));
        OP_BLTU: taken_c[i] = (a < b);
        OP_BGEU: taken_c[i] = !(a < b);
        OP_JR:   taken_c[i] = 1'b1;
        default: taken_c[i] = 1'b0;
      endcase
      is_br_c[i] = (op != OP_NONE);
      mis_c[i]   = is_br_c[i] && (taken_c[i] != bus.pred_taken[i]);
    end
  end

  // Oldest mispredict wins; younger slots are squashed from the count.
  always_comb begin
    found_c  = 1'b0;
    win_pc_c = bus.fallthru;
    inc_c    = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!found_c) begin
        if (is_br_c[i]) begin
          inc_c = inc_c + CW'(1);
        end
        if (mis_c[i]) begin
          found_c  = 1'b1;
          win_pc_c = taken_c[i] ? bus.target[i*XLEN +: XLEN] : bus.fallthru;
        end
      end
    end
  end

  assign acc_c = bus.valid && !bus.stall && !flush_q;

  // Next-state: redirect pulse, flush countdown and event counters.
  always_comb begin
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    fcnt_d           = (fcnt_q != '0) ? (fcnt_q - FW'(1)) : '0;
    cnt_branch_d     = cnt_branch_q;
    cnt_mispred_d    = cnt_mispred_q;
    if (acc_c) begin
      cnt_branch_d = cnt_branch_q + 32'(inc_c);
      if (found_c) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = win_pc_c;
        fcnt_d           = FW'(FLUSH_LEN);
        cnt_mispred_d    = cnt_mispred_q + 32'd1;
      end
    end
    flush_d = (fcnt_d != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      fcnt_q           <= '0;
      flush_q          <= 1'b0;
      cnt_branch_q     <= '0;
      cnt_mispred_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      fcnt_q           <= fcnt_d;
      flush_q          <= flush_d;
      cnt_branch_q     <= cnt_branch_d;
      cnt_mispred_q    <= cnt_mispred_d;
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.cnt_branch     = cnt_branch_q;
  assign bus.cnt_mispred    = cnt_mispred_q;

endmodule
